// File: rtl/line_stream_tx.sv
// line_stream_tx: transmit end of the line-buffer pixel stream.
// Pixels arrive over a valid/ready handshake into a small elastic FIFO and
// leave as a fixed-geometry raster stream (data/dv/line_end/frame_end).
// Line timing never stretches: an empty FIFO in an active slot still emits
// dv with zero data and sets the sticky underrun flag.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-low reset
//   en          frame enable, sampled in IDLE and at frame boundaries
//   data_i      upstream pixel
//   valid_i     upstream pixel valid
//   ready_o     FIFO can accept (transfer on valid_i && ready_o)
//   data_o      pixel to line buffer (registered)
//   dv_o        data_o valid during active region (registered)
//   line_end_o  pulse on last clock of each line period (registered)
//   frame_end_o pulse with line_end_o of the last line of a frame
//   underrun_o  sticky: an active slot found the FIFO empty
module line_stream_tx #(
  parameter int COLORDEPTH   = 8,
  parameter int SCREENWIDTH  = 1600,
  parameter int LINE_END     = 2048,
  parameter int SCREENHEIGHT = 900,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [COLORDEPTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [COLORDEPTH-1:0] data_o,
  output logic                  dv_o,
  output logic                  line_end_o,
  output logic                  frame_end_o,
  output logic                  underrun_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int VW = (SCREENHEIGHT > 1) ? $clog2(SCREENHEIGHT) : 1;

  localparam logic [10:0]   H_ACT_LAST = 11'(SCREENWIDTH - 1);
  localparam logic [10:0]   H_LAST     = 11'(LINE_END - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(SCREENHEIGHT - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  state_t                state_q, state_d;
  logic [10:0]           hcnt_q, hcnt_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [COLORDEPTH-1:0] mem_q [FIFO_DEPTH];
  logic [COLORDEPTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  line_end_q, line_end_d;
  logic                  frame_end_q, frame_end_d;
  logic                  underrun_q, underrun_d;

  logic fifo_empty;
  logic push;
  logic pop;

  assign ready_o     = rst && (count_q != FIFO_FULL);
  assign data_o      = data_q;
  assign dv_o        = dv_q;
  assign line_end_o  = line_end_q;
  assign frame_end_o = frame_end_q;
  assign underrun_o  = underrun_q;

  always_comb begin
    fifo_empty = (count_q == '0);
    push       = valid_i && ready_o;
    // Only active slots consume pixels; an empty FIFO leaves the slot blank.
    pop        = (state_q == ACTIVE) && !fifo_empty;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    data_d      = '0;
    dv_d        = 1'b0;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    underrun_d  = underrun_q;

    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (en && !fifo_empty) state_d = ACTIVE;
      end
      ACTIVE: begin
        // dv stays high on underrun so downstream addressing keeps geometry.
        dv_d = 1'b1;
        if (fifo_empty) underrun_d = 1'b1;
        else            data_d     = mem_q[rd_ptr_q];
        hcnt_d = hcnt_q + 11'd1;
        if (hcnt_q == H_ACT_LAST) state_d = BLANK;
      end
      BLANK: begin
        hcnt_d = hcnt_q + 11'd1;
        if (hcnt_q == H_LAST) begin
          hcnt_d     = '0;
          line_end_d = 1'b1;
          state_d    = ACTIVE;
          if (vcnt_q == V_LAST) begin
            // Frame boundary: the only point (besides IDLE) where en matters.
            frame_end_d = 1'b1;
            vcnt_d      = '0;
            if (!en) state_d = IDLE;
          end else begin
            vcnt_d = vcnt_q + VW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      underrun_q  <= underrun_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_line_stream_tx.sv
module tb_line_stream_tx;

  localparam int CD = 8;
  localparam int SW = 4;
  localparam int LE = 8;
  localparam int SH = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [CD-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [CD-1:0] data_o;
  logic          dv_o;
  logic          line_end_o;
  logic          frame_end_o;
  logic          underrun_o;

  int n_cmp = 0;
  int n_bad = 0;

  line_stream_tx #(
    .COLORDEPTH  (CD),
    .SCREENWIDTH (SW),
    .LINE_END    (LE),
    .SCREENHEIGHT(SH),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .dv_o       (dv_o),
    .line_end_o (line_end_o),
    .frame_end_o(frame_end_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, want);
    end
  endtask

  // Stream model: position within the line period, line index, a queue as
  // the FIFO. Evaluated at each clock edge, compared shortly after it.
  logic [CD-1:0] mq[$];
  int            m_pos = 0;
  int            m_line = 0;
  bit            m_run = 0;
  bit            m_und = 0;
  logic [CD-1:0] e_data;
  bit            e_dv, e_le, e_fe;

  always @(posedge clk) begin
    bit push;
    push   = rst && valid_i && (mq.size() < FD);
    e_dv   = 0;
    e_data = '0;
    e_le   = 0;
    e_fe   = 0;
    if (!rst) begin
      mq.delete();
      m_run  = 0;
      m_pos  = 0;
      m_line = 0;
      m_und  = 0;
    end else begin
      if (!m_run) begin
        if (en && mq.size() != 0) begin
          m_run  = 1;
          m_pos  = 0;
          m_line = 0;
        end
      end else begin
        if (m_pos < SW) begin
          e_dv = 1;
          if (mq.size() != 0) e_data = mq.pop_front();
          else                m_und  = 1;
        end
        if (m_pos == LE - 1) begin
          e_le  = 1;
          e_fe  = (m_line == SH - 1);
          m_pos = 0;
          if (m_line == SH - 1) begin
            m_line = 0;
            m_run  = en;
          end else begin
            m_line++;
          end
        end else begin
          m_pos++;
        end
      end
      if (push) mq.push_back(data_i);
    end
    #1;
    chk("dv_o", 32'(dv_o), 32'(e_dv));
    chk("data_o", 32'(data_o), 32'(e_data));
    chk("line_end_o", 32'(line_end_o), 32'(e_le));
    chk("frame_end_o", 32'(frame_end_o), 32'(e_fe));
    chk("underrun_o", 32'(underrun_o), 32'(m_und));
    chk("ready_o", 32'(ready_o), 32'(rst && (mq.size() < FD)));
  end

  task automatic do_reset();
    rst     = 1'b0;
    en      = 1'b0;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the caller at the negedge where dv_o is first seen high.
  task automatic wait_dv(input string nm, input bit bump, output bit ok);
    int w;
    w = 0;
    while (!dv_o && w < 30) begin
      @(negedge clk);
      if (bump) data_i = data_i + 8'd1;
      w++;
    end
    ok = dv_o;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: dv_o never rose, got 0 expected 1", nm);
    end
  endtask

  bit ok;
  logic [CD-1:0] cap_data [16];
  bit cap_dv [16];
  bit cap_le [16];
  bit cap_fe [16];
  int dv_cnt;
  bit fe_seen;

  initial begin
    // 1: reset holds everything low, valid ignored
    rst = 1'b0; valid_i = 1'b1; data_i = 8'h55; en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dv", 32'(dv_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_le", 32'(line_end_o), 0);
    chk("rst_fe", 32'(frame_end_o), 0);
    chk("rst_und", 32'(underrun_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_o), 1);
    chk("post_rst_dv", 32'(dv_o), 0);

    // 2: continuous push 0x10..0x17 over one full frame
    en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          valid_i = 1'b1;
          data_i  = 8'h10 + 8'(i);
          @(negedge clk);
        end
        valid_i = 1'b0;
        en      = 1'b0;
      end
      begin
        wait_dv("t2_start", 0, ok);
        for (int k = 0; k < 16; k++) begin
          cap_dv[k]   = dv_o;
          cap_data[k] = data_o;
          cap_le[k]   = line_end_o;
          cap_fe[k]   = frame_end_o;
          @(negedge clk);
        end
      end
    join
    for (int k = 0; k < 16; k++) begin
      logic [CD-1:0] wd;
      wd = ((k % 8) < 4) ? 8'(8'h10 + (k / 8) * 4 + (k % 8)) : 8'h00;
      chk("t2_dv", 32'(cap_dv[k]), 32'((k % 8) < 4));
      chk("t2_data", 32'(cap_data[k]), 32'(wd));
      chk("t2_le", 32'(cap_le[k]), 32'(k == 7 || k == 15));
      chk("t2_fe", 32'(cap_fe[k]), 32'(k == 15));
    end
    chk("t2_und", 32'(underrun_o), 0);
    repeat (4) @(negedge clk);
    chk("t2_idle_dv", 32'(dv_o), 0);

    // 3: fill FIFO with en low, 5th push refused
    do_reset();
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i = 8'h30 + 8'(i);
      @(negedge clk);
    end
    chk("t3_full_ready", 32'(ready_o), 0);
    valid_i = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("t3_pre_ready", 32'(ready_o), 0);
    chk("t3_pre_dv", 32'(dv_o), 0);
    @(negedge clk);
    chk("t3_pop_ready", 32'(ready_o), 1);
    chk("t3_d0", 32'(data_o), 32'h30);
    chk("t3_dv0", 32'(dv_o), 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t3_dn", 32'(data_o), 32'(8'h30 + 8'(i)));
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_l1_dv", 32'(dv_o), 1);
    chk("t3_l1_data", 32'(data_o), 0);
    chk("t3_l1_und", 32'(underrun_o), 1);
    repeat (8) @(negedge clk);

    // 4: underrun after two preloaded pixels
    do_reset();
    valid_i = 1'b1; data_i = 8'hA1;
    @(negedge clk);
    data_i = 8'hA2;
    @(negedge clk);
    valid_i = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("t4_pre_dv", 32'(dv_o), 0);
    @(negedge clk);
    chk("t4_a1", 32'(data_o), 32'hA1);
    chk("t4_und0", 32'(underrun_o), 0);
    @(negedge clk);
    chk("t4_a2", 32'(data_o), 32'hA2);
    chk("t4_und1", 32'(underrun_o), 0);
    @(negedge clk);
    chk("t4_s2_dv", 32'(dv_o), 1);
    chk("t4_s2_data", 32'(data_o), 0);
    chk("t4_s2_und", 32'(underrun_o), 1);
    @(negedge clk);
    chk("t4_s3_dv", 32'(dv_o), 1);
    chk("t4_s3_und", 32'(underrun_o), 1);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_l1_dv", 32'(dv_o), 1);
    chk("t4_l1_und", 32'(underrun_o), 1);
    repeat (8) @(negedge clk);

    // 5: en dropped in line 0, frame completes, then stays idle
    do_reset();
    en = 1'b1; valid_i = 1'b1; data_i = 8'h50;
    dv_cnt = 0; fe_seen = 0;
    for (int w = 0; w < 60 && !fe_seen; w++) begin
      if (dv_o) dv_cnt++;
      if (frame_end_o) begin
        fe_seen = 1;
        chk("t5_fe_le", 32'(line_end_o), 1);
      end else begin
        if (dv_cnt == 2) en = 1'b0;
        data_i = data_i + 8'd1;
        @(negedge clk);
      end
    end
    chk("t5_fe_seen", 32'(fe_seen), 1);
    chk("t5_dv_cnt", 32'(dv_cnt), 2 * SW);
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      chk("t5_idle_dv", 32'(dv_o), 0);
    end
    chk("t5_full_ready", 32'(ready_o), 0);
    valid_i = 1'b0;

    // 6: reset on the third active pixel, then a clean restart
    do_reset();
    en = 1'b1; valid_i = 1'b1; data_i = 8'h60;
    wait_dv("t6_start", 1, ok);
    chk("t6_first", 32'(data_o), 32'h60);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("t6_rst_dv", 32'(dv_o), 0);
    chk("t6_rst_data", 32'(data_o), 0);
    chk("t6_rst_ready", 32'(ready_o), 0);
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("t6_rel_ready", 32'(ready_o), 1);
    repeat (3) begin
      @(negedge clk);
      chk("t6_empty_dv", 32'(dv_o), 0);
    end
    valid_i = 1'b1; data_i = 8'h70;
    wait_dv("t6_restart", 1, ok);
    chk("t6_restart_data", 32'(data_o), 32'h70);
    chk("t6_restart_und", 32'(underrun_o), 0);
    en = 1'b0; valid_i = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
